// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_pipe data memory.
package dmem_pkg;

  localparam int BYTE_W       = 8;
  localparam int MAX_READ_LAT = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Control half of the response; the data word travels alongside at the instance's DATA_W.
  typedef struct packed {
    logic valid;
    logic write;
    logic err;
  } resp_hdr_t;

endpackage

// File: rtl/dmem_lat_pipe.sv
// LAT-stage shift register carrying {valid, write, err, data} from acceptance to response.
module dmem_lat_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  resp_hdr_t         in_hdr,
  input  logic [DATA_W-1:0] in_data,
  output resp_hdr_t         out_hdr,
  output logic [DATA_W-1:0] out_data
);

  typedef struct packed {
    resp_hdr_t         hdr;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t stage_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= '{hdr: in_hdr, data: in_data};
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_hdr  = stage_q[LAT-1].hdr;
  assign out_data = stage_q[LAT-1].data;

endmodule

// File: rtl/dmem_pipe.sv
// Word-addressed RAM with byte enables, fixed read latency and in-order responses.
// Define DMEM_CLEAR_EN to zero the array after reset before requests are accepted.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/BYTE_W-1:0] req_be,
  output logic                     resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     resp_err
);

  localparam int              NB      = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] out_data;
  resp_hdr_t         in_hdr;
  resp_hdr_t         out_hdr;

  assign in_range = ({1'b0, req_addr} < DEPTH_V);
  assign accept   = req_valid && req_ready;
  assign rd_word  = in_range ? mem[req_addr] : '0;

`ifdef DMEM_CLEAR_EN
  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last;

  assign clr_last = (clr_cnt == ADDR_W'(DEPTH-1));
  assign clr_addr = clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_last) state_d = ST_READY;
      end
      ST_READY: req_ready = 1'b1;
      default:  state_d = ST_CLEAR;
    endcase
  end
`else
  assign req_ready = rst_n;
  assign clr_we    = 1'b0;
  assign clr_addr  = '0;
`endif

  // Clear and request writes never overlap: req_ready is low while clearing.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (accept && req_write && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) mem[req_addr][b*BYTE_W +: BYTE_W] <= req_wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    in_hdr = '0;
    if (accept) begin
      in_hdr.valid = 1'b1;
      in_hdr.write = req_write;
      in_hdr.err   = !in_range;
    end
  end

  dmem_lat_pipe #(
    .DATA_W (DATA_W),
    .LAT    (READ_LAT)
  ) u_lat_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_hdr   (in_hdr),
    .in_data  (rd_word),
    .out_hdr  (out_hdr),
    .out_data (out_data)
  );

  assign resp_valid = out_hdr.valid;
  assign resp_err   = out_hdr.valid && out_hdr.err;
  assign resp_rdata = (out_hdr.valid && !out_hdr.write && !out_hdr.err) ? out_data : '0;

endmodule
